// File: rtl/adc_link_align_seq.sv
`default_nettype none
// =============================================================================
// Module      : adc_link_align_seq
// Description : Bring-up sequencer for one ADC LVDS link: SERDES reset, bit-clock
//               and frame alignment, lock qualification, loss detection, retry.
// Revision    : 1.0 - initial release
// =============================================================================
module adc_link_align_seq #(
    parameter int ADC_BITS       = 14,
    parameter int RST_CYCLES     = 16,
    parameter int BITCLK_TIMEOUT = 4096,
    parameter int FRM_TIMEOUT    = 2048,
    parameter int SETTLE_CYCLES  = 64,
    parameter int DROP_FILTER    = 4,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       CtrlClkDiv,
    input  logic       CtrlRst,
    input  logic       Enable,
    input  logic       Retrain,
    input  logic       BitClkDone,
    input  logic       FrmAlignDone,
    input  logic       FrmBitslip,
    output logic       SerdesRst,
    output logic       LinkUp,
    output logic       LinkFail,
    output logic [3:0] RetryCnt,
    output logic [7:0] BitslipCnt,
    output logic [7:0] LossCnt,
    output logic [2:0] State
);

    localparam int c_TMAX_A   = (RST_CYCLES > BITCLK_TIMEOUT) ? RST_CYCLES : BITCLK_TIMEOUT;
    localparam int c_TMAX     = (c_TMAX_A > FRM_TIMEOUT) ? c_TMAX_A : FRM_TIMEOUT;
    localparam int c_TIMER_W  = $clog2(c_TMAX + 1);
    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int c_DROP_W   = $clog2(DROP_FILTER + 1);

    localparam logic [c_TIMER_W-1:0]  c_RST_LAST    = c_TIMER_W'(RST_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0]  c_BITCLK_LAST = c_TIMER_W'(BITCLK_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0]  c_FRM_LAST    = c_TIMER_W'(FRM_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0]  c_TIMER_MAX   = '1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [c_DROP_W-1:0]   c_DROP_LAST   = c_DROP_W'(DROP_FILTER - 1);
    localparam logic [7:0]            c_SLIP_MAX    = 8'(2 * ADC_BITS);
    localparam logic [3:0]            c_MAX_RETRY   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RST_SERDES  = 3'd1,
        S_WAIT_BITCLK = 3'd2,
        S_WAIT_FRAME  = 3'd3,
        S_SETTLE      = 3'd4,
        S_LOCKED      = 3'd5,
        S_RETRY       = 3'd6,
        S_FAIL        = 3'd7
    } state_t;

    state_t                r_state, w_stateNext;
    logic [c_TIMER_W-1:0]  r_timer, w_timerNext;
    logic [c_SETTLE_W-1:0] r_settleCnt, w_settleNext;
    logic [c_DROP_W-1:0]   r_dropCnt, w_dropNext;
    logic [3:0]            r_retryCnt, w_retryNext;
    logic [7:0]            r_bitslipCnt, w_bitslipNext;
    logic [7:0]            r_lossCnt, w_lossNext;
    logic                  r_serdesRst, r_linkUp, r_linkFail;
    logic                  w_frmAbort;

    always_ff @(posedge CtrlClkDiv) begin
        if (CtrlRst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_settleCnt  <= '0;
            r_dropCnt    <= '0;
            r_retryCnt   <= '0;
            r_bitslipCnt <= '0;
            r_lossCnt    <= '0;
            r_serdesRst  <= 1'b1;
            r_linkUp     <= 1'b0;
            r_linkFail   <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_timer      <= w_timerNext;
            r_settleCnt  <= w_settleNext;
            r_dropCnt    <= w_dropNext;
            r_retryCnt   <= w_retryNext;
            r_bitslipCnt <= w_bitslipNext;
            r_lossCnt    <= w_lossNext;
            // Outputs are registered copies of the decode of the next state
            r_serdesRst  <= (w_stateNext == S_IDLE) || (w_stateNext == S_RST_SERDES) ||
                            (w_stateNext == S_FAIL);
            r_linkUp     <= (w_stateNext == S_LOCKED);
            r_linkFail   <= (w_stateNext == S_FAIL);
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_timerNext   = (r_timer == c_TIMER_MAX) ? r_timer : r_timer + 1'b1;
        w_settleNext  = r_settleCnt;
        w_dropNext    = r_dropCnt;
        w_retryNext   = r_retryCnt;
        w_lossNext    = r_lossCnt;
        w_bitslipNext = r_bitslipCnt;
        // One timer spans WAIT_FRAME and SETTLE so glitchy alignment cannot extend an attempt
        w_frmAbort    = !BitClkDone || (r_bitslipCnt > c_SLIP_MAX) || (r_timer == c_FRM_LAST);

        if (!Enable) begin
            w_stateNext = S_IDLE;
            w_retryNext = '0;
            w_timerNext = '0;
        end else if (Retrain && (r_state != S_IDLE)) begin
            w_stateNext = S_RST_SERDES;
            w_retryNext = '0;
            w_timerNext = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_stateNext = S_RST_SERDES;
                    w_timerNext = '0;
                end
                S_RST_SERDES: begin
                    if (r_timer == c_RST_LAST) begin
                        w_stateNext = S_WAIT_BITCLK;
                        w_timerNext = '0;
                    end
                end
                S_WAIT_BITCLK: begin
                    if (BitClkDone) begin
                        w_stateNext = S_WAIT_FRAME;
                        w_timerNext = '0;
                    end else if (r_timer == c_BITCLK_LAST) begin
                        w_stateNext = S_RETRY;
                    end
                end
                S_WAIT_FRAME: begin
                    if (w_frmAbort) begin
                        w_stateNext = S_RETRY;
                    end else if (FrmAlignDone) begin
                        w_stateNext  = S_SETTLE;
                        w_settleNext = c_SETTLE_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (w_frmAbort) begin
                        w_stateNext = S_RETRY;
                    end else if (!FrmAlignDone) begin
                        w_stateNext  = S_WAIT_FRAME;
                        w_settleNext = '0;
                    end else if (r_settleCnt == c_SETTLE_LAST) begin
                        w_stateNext = S_LOCKED;
                        w_dropNext  = '0;
                    end else begin
                        w_settleNext = r_settleCnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!BitClkDone || (!FrmAlignDone && (r_dropCnt == c_DROP_LAST))) begin
                        w_stateNext = S_RST_SERDES;
                        w_timerNext = '0;
                        w_retryNext = '0;
                        w_lossNext  = (r_lossCnt == 8'hFF) ? r_lossCnt : r_lossCnt + 8'd1;
                    end else if (FrmAlignDone) begin
                        w_dropNext = '0;
                    end else begin
                        w_dropNext = r_dropCnt + 1'b1;
                    end
                end
                S_RETRY: begin
                    if (r_retryCnt == c_MAX_RETRY) begin
                        w_stateNext = S_FAIL;
                    end else begin
                        w_stateNext = S_RST_SERDES;
                        w_timerNext = '0;
                        w_retryNext = (r_retryCnt == 4'hF) ? r_retryCnt : r_retryCnt + 4'd1;
                    end
                end
                S_FAIL: begin
                    w_stateNext = S_FAIL;
                end
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end

        // A slip seen on an aborting cycle still counts; every new attempt starts from zero
        if (((r_state == S_WAIT_FRAME) || (r_state == S_SETTLE)) && FrmBitslip &&
            (r_bitslipCnt != 8'hFF)) begin
            w_bitslipNext = r_bitslipCnt + 8'd1;
        end
        if (w_stateNext == S_RST_SERDES) begin
            w_bitslipNext = '0;
        end
    end

    assign SerdesRst  = r_serdesRst;
    assign LinkUp     = r_linkUp;
    assign LinkFail   = r_linkFail;
    assign RetryCnt   = r_retryCnt;
    assign BitslipCnt = r_bitslipCnt;
    assign LossCnt    = r_lossCnt;
    assign State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_adc_link_align_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_adc_link_align_seq
// Description : Directed self-checking bench for the ADC link bring-up sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_adc_link_align_seq;

    logic       CtrlClkDiv = 1'b0;
    logic       CtrlRst, Enable, Retrain, BitClkDone, FrmAlignDone, FrmBitslip;
    logic       SerdesRst, LinkUp, LinkFail;
    logic [3:0] RetryCnt;
    logic [7:0] BitslipCnt, LossCnt;
    logic [2:0] State;
    int         vectors = 0;
    int         errors  = 0;

    adc_link_align_seq dut (
        .CtrlClkDiv  (CtrlClkDiv),
        .CtrlRst     (CtrlRst),
        .Enable      (Enable),
        .Retrain     (Retrain),
        .BitClkDone  (BitClkDone),
        .FrmAlignDone(FrmAlignDone),
        .FrmBitslip  (FrmBitslip),
        .SerdesRst   (SerdesRst),
        .LinkUp      (LinkUp),
        .LinkFail    (LinkFail),
        .RetryCnt    (RetryCnt),
        .BitslipCnt  (BitslipCnt),
        .LossCnt     (LossCnt),
        .State       (State)
    );

    always #5 CtrlClkDiv = ~CtrlClkDiv;

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge CtrlClkDiv);
    endtask

    task automatic test_reset();
        CtrlRst = 1'b1; Enable = 1'b1; Retrain = 1'b0;
        BitClkDone = 1'b0; FrmAlignDone = 1'b0; FrmBitslip = 1'b0;
        step(3);
        vectors++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
        vectors++; if (SerdesRst !== 1'b1) begin errors++; $display("FAIL reset_serdesrst: got %b expected 1", SerdesRst); end
        vectors++; if (LinkUp !== 1'b0 || LinkFail !== 1'b0) begin errors++; $display("FAIL reset_flags: LinkUp=%b LinkFail=%b expected 0 0", LinkUp, LinkFail); end
        vectors++; if (RetryCnt !== 4'd0 || BitslipCnt !== 8'd0 || LossCnt !== 8'd0) begin errors++; $display("FAIL reset_counters: Retry=%0d Slip=%0d Loss=%0d expected 0 0 0", RetryCnt, BitslipCnt, LossCnt); end
        Enable = 1'b0; CtrlRst = 1'b0;
    endtask

    task automatic test_bringup();
        Enable = 1'b1; BitClkDone = 1'b1;
        step(1);
        vectors++; if (State !== 3'd1 || SerdesRst !== 1'b1) begin errors++; $display("FAIL bringup_rst_entry: State=%0d SerdesRst=%b expected 1 1", State, SerdesRst); end
        step(15);
        vectors++; if (State !== 3'd1 || SerdesRst !== 1'b1) begin errors++; $display("FAIL bringup_rst_cycle16: State=%0d SerdesRst=%b expected 1 1", State, SerdesRst); end
        step(1);
        vectors++; if (State !== 3'd2 || SerdesRst !== 1'b0) begin errors++; $display("FAIL bringup_cycle17: State=%0d SerdesRst=%b expected 2 0", State, SerdesRst); end
        step(1);
        vectors++; if (State !== 3'd3) begin errors++; $display("FAIL bringup_wait_frame: State=%0d expected 3", State); end
        step(1);
        FrmAlignDone = 1'b1;
        step(63);
        vectors++; if (State !== 3'd4 || LinkUp !== 1'b0) begin errors++; $display("FAIL bringup_settle63: State=%0d LinkUp=%b expected 4 0", State, LinkUp); end
        step(1);
        vectors++; if (State !== 3'd5 || LinkUp !== 1'b1 || SerdesRst !== 1'b0) begin errors++; $display("FAIL bringup_locked: State=%0d LinkUp=%b SerdesRst=%b expected 5 1 0", State, LinkUp, SerdesRst); end
    endtask

    task automatic test_drop_filter();
        FrmAlignDone = 1'b0;
        step(3);
        vectors++; if (State !== 3'd5 || LinkUp !== 1'b1) begin errors++; $display("FAIL drop_low3: State=%0d LinkUp=%b expected 5 1", State, LinkUp); end
        FrmAlignDone = 1'b1;
        step(1);
        FrmAlignDone = 1'b0;
        step(3);
        vectors++; if (State !== 3'd5 || LossCnt !== 8'd0) begin errors++; $display("FAIL drop_low3_after_clear: State=%0d LossCnt=%0d expected 5 0", State, LossCnt); end
        step(1);
        vectors++; if (State !== 3'd1 || LinkUp !== 1'b0 || LossCnt !== 8'd1) begin errors++; $display("FAIL drop_low4: State=%0d LinkUp=%b LossCnt=%0d expected 1 0 1", State, LinkUp, LossCnt); end
    endtask

    task automatic test_settle_glitch();
        step(16);
        vectors++; if (State !== 3'd2) begin errors++; $display("FAIL glitch_wait_bitclk: State=%0d expected 2", State); end
        step(1);
        FrmAlignDone = 1'b1;
        step(40);
        vectors++; if (State !== 3'd4) begin errors++; $display("FAIL glitch_settle40: State=%0d expected 4", State); end
        FrmAlignDone = 1'b0;
        step(1);
        vectors++; if (State !== 3'd3) begin errors++; $display("FAIL glitch_back_to_frame: State=%0d expected 3", State); end
        FrmAlignDone = 1'b1;
        step(63);
        vectors++; if (State !== 3'd4 || LinkUp !== 1'b0) begin errors++; $display("FAIL glitch_fresh63: State=%0d LinkUp=%b expected 4 0", State, LinkUp); end
        step(1);
        vectors++; if (State !== 3'd5 || LinkUp !== 1'b1) begin errors++; $display("FAIL glitch_fresh64: State=%0d LinkUp=%b expected 5 1", State, LinkUp); end
    endtask

    task automatic test_bitclk_loss();
        BitClkDone = 1'b0;
        step(1);
        vectors++; if (State !== 3'd1 || LinkUp !== 1'b0 || LossCnt !== 8'd2) begin errors++; $display("FAIL bitclk_loss: State=%0d LinkUp=%b LossCnt=%0d expected 1 0 2", State, LinkUp, LossCnt); end
        BitClkDone = 1'b1;
    endtask

    task automatic test_bitslip();
        CtrlRst = 1'b1; FrmAlignDone = 1'b0;
        step(2);
        vectors++; if (State !== 3'd0 || LossCnt !== 8'd0) begin errors++; $display("FAIL slip_reset: State=%0d LossCnt=%0d expected 0 0", State, LossCnt); end
        CtrlRst = 1'b0;
        step(18);
        vectors++; if (State !== 3'd3 || BitslipCnt !== 8'd0) begin errors++; $display("FAIL slip_start: State=%0d BitslipCnt=%0d expected 3 0", State, BitslipCnt); end
        FrmBitslip = 1'b1;
        step(29);
        vectors++; if (State !== 3'd3 || BitslipCnt !== 8'd29) begin errors++; $display("FAIL slip_29: State=%0d BitslipCnt=%0d expected 3 29", State, BitslipCnt); end
        step(1);
        vectors++; if (State !== 3'd6 || BitslipCnt !== 8'd30) begin errors++; $display("FAIL slip_abort: State=%0d BitslipCnt=%0d expected 6 30", State, BitslipCnt); end
        FrmBitslip = 1'b0;
        step(1);
        vectors++; if (State !== 3'd1 || BitslipCnt !== 8'd0 || RetryCnt !== 4'd1) begin errors++; $display("FAIL slip_retry: State=%0d BitslipCnt=%0d RetryCnt=%0d expected 1 0 1", State, BitslipCnt, RetryCnt); end
    endtask

    task automatic test_retry_fail();
        CtrlRst = 1'b1;
        step(2);
        CtrlRst = 1'b0;
        step(18);
        vectors++; if (State !== 3'd3 || RetryCnt !== 4'd0) begin errors++; $display("FAIL retry_a0_frame: State=%0d RetryCnt=%0d expected 3 0", State, RetryCnt); end
        step(2047);
        vectors++; if (State !== 3'd3) begin errors++; $display("FAIL retry_a0_before_timeout: State=%0d expected 3", State); end
        step(1);
        vectors++; if (State !== 3'd6) begin errors++; $display("FAIL retry_a0_timeout: State=%0d expected 6", State); end
        step(1);
        vectors++; if (State !== 3'd1 || RetryCnt !== 4'd1) begin errors++; $display("FAIL retry_a0_restart: State=%0d RetryCnt=%0d expected 1 1", State, RetryCnt); end
        for (int r = 1; r <= 3; r++) begin
            step(17);
            vectors++; if (State !== 3'd3 || RetryCnt !== 4'(r)) begin errors++; $display("FAIL retry_a%0d_frame: State=%0d RetryCnt=%0d expected 3 %0d", r, State, RetryCnt, r); end
            step(2048);
            vectors++; if (State !== 3'd6) begin errors++; $display("FAIL retry_a%0d_timeout: State=%0d expected 6", r, State); end
            step(1);
            if (r < 3) begin
                vectors++; if (State !== 3'd1 || RetryCnt !== 4'(r + 1)) begin errors++; $display("FAIL retry_a%0d_restart: State=%0d RetryCnt=%0d expected 1 %0d", r, State, RetryCnt, r + 1); end
            end else begin
                vectors++; if (State !== 3'd7 || LinkFail !== 1'b1 || SerdesRst !== 1'b1 || RetryCnt !== 4'd3) begin errors++; $display("FAIL retry_fail: State=%0d LinkFail=%b SerdesRst=%b RetryCnt=%0d expected 7 1 1 3", State, LinkFail, SerdesRst, RetryCnt); end
            end
        end
        step(5);
        vectors++; if (State !== 3'd7 || LinkUp !== 1'b0) begin errors++; $display("FAIL fail_hold: State=%0d LinkUp=%b expected 7 0", State, LinkUp); end
        Retrain = 1'b1;
        step(1);
        Retrain = 1'b0;
        vectors++; if (State !== 3'd1 || RetryCnt !== 4'd0 || LinkFail !== 1'b0) begin errors++; $display("FAIL fail_retrain: State=%0d RetryCnt=%0d LinkFail=%b expected 1 0 0", State, RetryCnt, LinkFail); end
    endtask

    task automatic test_enable_abort();
        step(17);
        vectors++; if (State !== 3'd3) begin errors++; $display("FAIL enable_frame: State=%0d expected 3", State); end
        Enable = 1'b0;
        step(1);
        vectors++; if (State !== 3'd0 || SerdesRst !== 1'b1 || RetryCnt !== 4'd0) begin errors++; $display("FAIL enable_idle: State=%0d SerdesRst=%b RetryCnt=%0d expected 0 1 0", State, SerdesRst, RetryCnt); end
        Retrain = 1'b1;
        step(1);
        Retrain = 1'b0;
        vectors++; if (State !== 3'd0) begin errors++; $display("FAIL retrain_in_idle: State=%0d expected 0", State); end
        Enable = 1'b1;
        step(1);
        vectors++; if (State !== 3'd1) begin errors++; $display("FAIL enable_restart: State=%0d expected 1", State); end
    endtask

    task automatic test_bitclk_timeout();
        BitClkDone = 1'b0;
        step(16);
        vectors++; if (State !== 3'd2) begin errors++; $display("FAIL bctimeout_enter: State=%0d expected 2", State); end
        step(4095);
        vectors++; if (State !== 3'd2) begin errors++; $display("FAIL bctimeout_before: State=%0d expected 2", State); end
        step(1);
        vectors++; if (State !== 3'd6) begin errors++; $display("FAIL bctimeout_retry: State=%0d expected 6", State); end
        step(1);
        vectors++; if (State !== 3'd1 || RetryCnt !== 4'd1) begin errors++; $display("FAIL bctimeout_restart: State=%0d RetryCnt=%0d expected 1 1", State, RetryCnt); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_drop_filter();
        test_settle_glitch();
        test_bitclk_loss();
        test_bitslip();
        test_retry_fail();
        test_enable_abort();
        test_bitclk_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
